serial_bit_feeder: RTL and testbench
====================================

# serial_bit_feeder

Parallel-to-serial front end for the bit-stream sequence detectors. It accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clock, on a registered serial output. That output drives the detector's `x` input directly. A one-word holding buffer lets consecutive words stream with no idle gap, so patterns spanning a word boundary (e.g. 101 across bytes) reach the detector intact.

## Interface
- WIDTH, 8, data bits per word; legal range 2..32
- IDLE_BIT, 1'b0, value driven on `x` whenever no word is being shifted
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in_data  input  WIDTH  parallel word, sampled on accept
- in_valid  input  1  upstream word available
- in_ready  output  1  holding buffer empty; accept = in_valid && in_ready at a rising edge
- x  output  1  serial bit to detector (registered)
- x_valid  output  1  high while `x` carries a data or parity bit (registered)
- word_done  output  1  high during the cycle `x` carries the final bit of a word (registered)
- busy  output  1  shifting, or holding buffer full

## Operation
- Storage:
  - hold register + hold_full flag
  - shift register sh[WIDTH-1:0]
  - bit counter cnt, width clog2(WIDTH+1)
- `in_ready = rst && !hold_full`. Accept writes in_data to hold and sets hold_full.
- States: IDLE, SHIFT, PARITY (PARITY exists only with the macro).
- IDLE:
  - if hold_full: x<=hold[WIDTH-1], sh<=hold<<1, cnt<=1, hold_full<=0, x_valid<=1, go to SHIFT
  - else: x<=IDLE_BIT, x_valid<=0
- SHIFT, cnt<WIDTH: x<=sh[WIDTH-1], sh<=sh<<1, cnt<=cnt+1.
- SHIFT, cnt==WIDTH (last data bit currently on x):
  - hold_full: load next word exactly as in IDLE, stay in SHIFT (gapless)
  - else: go to IDLE, x<=IDLE_BIT, x_valid<=0
- word_done is registered high on the edge that puts the final bit of a word on x. It is never high for two consecutive cycles unless WIDTH==1, which is illegal.
- The hold buffer never accepts and transfers on the same edge, because in_ready is low while hold_full=1.
- Sustained throughput: one word per WIDTH cycles (WIDTH+1 with the macro). Upstream sees in_ready re-assert one cycle after each transfer.
- busy = (state!=IDLE) || hold_full.

## Timing
- Reset values (asynchronous, while rst=0):
  - state=IDLE, x=IDLE_BIT, x_valid=0, word_done=0
  - hold_full=0, cnt=0, sh=0, in_ready=0, busy=0
- After rst deasserts, in_ready=1 with no further delay.
- Latency: word accepted at edge N → MSB on x after edge N+1 → last data bit after edge N+WIDTH.
- Reset asserted mid-word: remaining bits and any held word are discarded, and x returns to IDLE_BIT immediately. No partial word resumes after reset.
- in_data and in_valid changing while in_ready=0 have no effect.

## Configuration
- `SERIAL_FEEDER_PARITY_EN` defined:
  - after the last data bit, state PARITY emits one even-parity bit (XOR of the word) with x_valid=1
  - word_done moves to the parity bit
  - the next held word loads from PARITY; period WIDTH+1
- Not defined:
  - no PARITY state or parity logic
  - word_done marks data bit WIDTH; period WIDTH

## Test plan
- Reset check: rst=0 for 2 cycles with in_valid=1 → x=0, x_valid=0, in_ready=0; after release in_ready=1 and nothing was accepted during reset.
- Single word: WIDTH=8, accept 8'hA5 → x sequence 1,0,1,0,0,1,0,1 starting one cycle after accept; word_done on the 8th bit; x=0, x_valid=0 the following cycle.
- Back-to-back: present 8'h05 then 8'hA0 with in_valid held high → 16 contiguous bits 0000010110100000 with x_valid never dropping. A downstream 101 detector fires across the word boundary.
- Backpressure: in_valid held high for 4 words → exactly 4 accepts; in_ready low from each capture edge until the transfer edge; no word lost or duplicated.
- Reset mid-word: assert rst after the 3rd bit of 8'hFF with 8'h81 held → x=0 immediately; no further x_valid; next accepted word 8'h80 emits cleanly.
- Parity (macro defined): 8'h07 → bits 00000111 then parity 1 with word_done on the parity bit; 8'h03 → parity 0; period 9 cycles back-to-back.

Source files
------------

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: WIDTH-bit words in over valid/ready, MSB-first bits out on x.
// Define SERIAL_FEEDER_PARITY_EN to append one even-parity bit after each word.
module serial_bit_feeder #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

`ifdef SERIAL_FEEDER_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;

  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction
`else
  localparam logic [CW-1:0] CNT_PRE_LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] hold_r, hold_nxt_s;
  logic             hold_full_r, hold_full_nxt_s;
  logic [WIDTH-1:0] sh_r, sh_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic             x_r, x_nxt_s;
  logic             x_valid_r, x_valid_nxt_s;
  logic             word_done_r, word_done_nxt_s;
  logic             load_s;
`ifdef SERIAL_FEEDER_PARITY_EN
  logic             par_r, par_nxt_s;
`endif

  assign in_ready  = rst && !hold_full_r;
  assign busy      = (state_r != IDLE) || hold_full_r;
  assign x         = x_r;
  assign x_valid   = x_valid_r;
  assign word_done = word_done_r;

  // Next-state, serializer and hold-buffer logic.
  always_comb begin
    state_nxt_s     = state_r;
    hold_nxt_s      = hold_r;
    hold_full_nxt_s = hold_full_r;
    sh_nxt_s        = sh_r;
    cnt_nxt_s       = cnt_r;
    x_nxt_s         = x_r;
    x_valid_nxt_s   = x_valid_r;
    word_done_nxt_s = 1'b0;
    load_s          = 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
    par_nxt_s       = par_r;
`endif
    case (state_r)
      IDLE: begin
        if (hold_full_r) begin
          load_s = 1'b1;
        end else begin
          x_nxt_s       = IDLE_BIT;
          x_valid_nxt_s = 1'b0;
        end
      end
      SHIFT: begin
        if (cnt_r != CNT_LAST) begin
          x_nxt_s   = sh_r[WIDTH-1];
          sh_nxt_s  = sh_r << 1'b1;
          cnt_nxt_s = cnt_r + CNT_ONE;
`ifdef SERIAL_FEEDER_PARITY_EN
          word_done_nxt_s = 1'b0;
        end else begin
          state_nxt_s     = PARITY;
          x_nxt_s         = par_r;
          x_valid_nxt_s   = 1'b1;
          word_done_nxt_s = 1'b1;
        end
      end
      PARITY: begin
        if (hold_full_r) begin
          load_s = 1'b1;
        end else begin
          state_nxt_s   = IDLE;
          x_nxt_s       = IDLE_BIT;
          x_valid_nxt_s = 1'b0;
        end
      end
`else
          word_done_nxt_s = (cnt_r == CNT_PRE_LAST);
        end else if (hold_full_r) begin
          load_s = 1'b1;
        end else begin
          state_nxt_s   = IDLE;
          x_nxt_s       = IDLE_BIT;
          x_valid_nxt_s = 1'b0;
        end
      end
`endif
      default: begin
        state_nxt_s   = IDLE;
        x_nxt_s       = IDLE_BIT;
        x_valid_nxt_s = 1'b0;
      end
    endcase

    // Load and accept are exclusive: a load needs hold_full, an accept needs it clear.
    if (load_s) begin
      state_nxt_s     = SHIFT;
      x_nxt_s         = hold_r[WIDTH-1];
      x_valid_nxt_s   = 1'b1;
      sh_nxt_s        = hold_r << 1'b1;
      cnt_nxt_s       = CNT_ONE;
      hold_full_nxt_s = 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
      par_nxt_s       = even_parity(hold_r);
`endif
    end else if (in_valid && in_ready) begin
      hold_nxt_s      = in_data;
      hold_full_nxt_s = 1'b1;
    end else begin
      hold_nxt_s      = hold_r;
    end
  end

  // State and datapath registers; reset discards any partial or held word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      hold_r      <= {WIDTH{1'b0}};
      hold_full_r <= 1'b0;
      sh_r        <= {WIDTH{1'b0}};
      cnt_r       <= CNT_ZERO;
      x_r         <= IDLE_BIT;
      x_valid_r   <= 1'b0;
      word_done_r <= 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
      par_r       <= 1'b0;
`endif
    end else begin
      state_r     <= state_nxt_s;
      hold_r      <= hold_nxt_s;
      hold_full_r <= hold_full_nxt_s;
      sh_r        <= sh_nxt_s;
      cnt_r       <= cnt_nxt_s;
      x_r         <= x_nxt_s;
      x_valid_r   <= x_valid_nxt_s;
      word_done_r <= word_done_nxt_s;
`ifdef SERIAL_FEEDER_PARITY_EN
      par_r       <= par_nxt_s;
`endif
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Self-checking bench for serial_bit_feeder: hand tables plus a frame-queue reference model.
module tb_serial_bit_feeder;
  localparam int W = 8;
  localparam logic IDLE_B = 1'b0;
`ifdef SERIAL_FEEDER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready, x, x_valid, word_done, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of {bit, done} frames still to go out, plus one held word.
  logic [1:0]   m_frames[$];
  logic         m_held;
  logic [W-1:0] m_hold_data;
  logic         m_x, m_xv, m_wd;
  logic [W-1:0] src_q[$];

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic [4:0]   exp;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(W), .IDLE_BIT(IDLE_B)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .x_valid(x_valid), .word_done(word_done), .busy(busy)
  );

  function automatic void model_reset();
    m_frames.delete();
    m_held = 1'b0; m_hold_data = '0;
    m_x = IDLE_B; m_xv = 1'b0; m_wd = 1'b0;
  endfunction

  function automatic logic model_edge(input logic v, input logic [W-1:0] d);
    logic acc;
    logic [1:0] f;
    acc = v && !m_held;
    if (m_frames.size() == 0 && m_held) begin
      for (int i = W - 1; i >= 0; i--) m_frames.push_back({m_hold_data[i], (i == 0) && !PAR});
      if (PAR) m_frames.push_back({^m_hold_data, 1'b1});
      m_held = 1'b0;
    end
    if (m_frames.size() > 0) begin
      f = m_frames.pop_front();
      m_x = f[1]; m_xv = 1'b1; m_wd = f[0];
    end else begin
      m_x = IDLE_B; m_xv = 1'b0; m_wd = 1'b0;
    end
    if (acc) begin
      m_held = 1'b1; m_hold_data = d;
    end
    return acc;
  endfunction

  function automatic logic [4:0] model_exp();
    return {m_x, m_xv, m_wd, !m_held, m_xv || m_held};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: {x,x_valid,word_done,in_ready,busy} got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle(input string name, input logic v, input logic [W-1:0] d, output logic acc);
    in_valid = v; in_data = d;
    acc = model_edge(v, d);
    @(posedge clk); #1;
    check(name, {x, x_valid, word_done, in_ready, busy}, model_exp());
  endtask

  task automatic apply_vec(input string name, input vec_t t);
    logic acc;
    in_valid = t.v; in_data = t.d;
    acc = model_edge(t.v, t.d);
    @(posedge clk); #1;
    check(name, {x, x_valid, word_done, in_ready, busy}, t.exp);
  endtask

  // Streams src_q through the DUT; valid_pct sets how often a word is offered.
  task automatic run_stream(input string name, input int valid_pct);
    logic acc, v;
    logic [W-1:0] d;
    int n_words, done_seen, budget;
    n_words = src_q.size(); done_seen = 0;
    budget = n_words * (W + 2) * 8 + 50;
    while ((src_q.size() > 0 || m_held || m_xv) && budget > 0) begin
      if (m_held) begin
        v = 1'($urandom_range(1, 0)); d = W'($urandom);
      end else begin
        v = (src_q.size() > 0) && ($urandom_range(99, 0) < valid_pct);
        d = v ? src_q[0] : W'($urandom);
      end
      cycle(name, v, d, acc);
      if (acc) void'(src_q.pop_front());
      if (word_done) done_seen++;
      budget--;
    end
    check_int({name, " finished in budget"}, (budget > 0) ? 1 : 0, 1);
    check_int({name, " word_done pulses"}, done_seen, n_words);
  endtask

  initial begin
    logic acc;
    rst = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("reset state", {x, x_valid, word_done, in_ready, busy}, {IDLE_B, 4'b0000});
    rst = 1'b1;
    #1;
    check("ready after release", {x, x_valid, word_done, in_ready, busy}, {IDLE_B, 4'b0010});
    cycle("nothing accepted in reset", 1'b0, 8'h00, acc);

`ifndef SERIAL_FEEDER_PARITY_EN
    tbl.push_back('{1'b1, 8'hA5, 5'b00001});
    tbl.push_back('{1'b0, 8'h00, 5'b11011}); tbl.push_back('{1'b0, 8'h00, 5'b01011});
    tbl.push_back('{1'b0, 8'h00, 5'b11011}); tbl.push_back('{1'b0, 8'h00, 5'b01011});
    tbl.push_back('{1'b0, 8'h00, 5'b01011}); tbl.push_back('{1'b0, 8'h00, 5'b11011});
    tbl.push_back('{1'b0, 8'h00, 5'b01011}); tbl.push_back('{1'b0, 8'h00, 5'b11111});
    tbl.push_back('{1'b0, 8'h00, 5'b00010});
    tbl.push_back('{1'b1, 8'h05, 5'b00001});
    tbl.push_back('{1'b1, 8'hA0, 5'b01011}); tbl.push_back('{1'b1, 8'hA0, 5'b01001});
    tbl.push_back('{1'b0, 8'h00, 5'b01001}); tbl.push_back('{1'b0, 8'h00, 5'b01001});
    tbl.push_back('{1'b0, 8'h00, 5'b01001}); tbl.push_back('{1'b0, 8'h00, 5'b11001});
    tbl.push_back('{1'b0, 8'h00, 5'b01001}); tbl.push_back('{1'b0, 8'h00, 5'b11101});
    tbl.push_back('{1'b0, 8'h00, 5'b11011}); tbl.push_back('{1'b0, 8'h00, 5'b01011});
    tbl.push_back('{1'b0, 8'h00, 5'b11011}); tbl.push_back('{1'b0, 8'h00, 5'b01011});
    tbl.push_back('{1'b0, 8'h00, 5'b01011}); tbl.push_back('{1'b0, 8'h00, 5'b01011});
    tbl.push_back('{1'b0, 8'h00, 5'b01011}); tbl.push_back('{1'b0, 8'h00, 5'b01111});
    tbl.push_back('{1'b0, 8'h00, 5'b00010});
    for (int i = 0; i < tbl.size(); i++) apply_vec((i < 10) ? "single A5" : "b2b 05/A0", tbl[i]);
`else
    src_q.push_back(8'h07); src_q.push_back(8'h03);
    run_stream("parity 07/03", 100);
`endif

    // Reset mid-word: FF shifting, 81 held.
    cycle("mid pre 1", 1'b1, 8'hFF, acc);
    cycle("mid pre 2", 1'b1, 8'h81, acc);
    cycle("mid pre 3", 1'b1, 8'h81, acc);
    cycle("mid pre 4", 1'b0, 8'h00, acc);
    #2 rst = 1'b0;
    #1;
    check("reset mid-word", {x, x_valid, word_done, in_ready, busy}, {IDLE_B, 4'b0000});
    model_reset();
    in_valid = 1'b1; in_data = 8'h81;
    @(posedge clk); #1;
    check("held in reset", {x, x_valid, word_done, in_ready, busy}, {IDLE_B, 4'b0000});
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cycle("idle after reset", 1'b0, 8'h00, acc);
    src_q.push_back(8'h80);
    run_stream("word 80 after reset", 100);

    for (int i = 0; i < 4; i++) src_q.push_back(W'($urandom));
    run_stream("backpressure 4 words", 100);

    for (int i = 0; i < 40; i++) src_q.push_back(W'($urandom));
    run_stream("random", 60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
